// File: rtl/membus_pkg.sv
// Shared types and constants for the multiplexed memory bus responder.
package membus_pkg;

    localparam int unsigned     MB_DATA_WIDTH = 16;
    localparam int unsigned     MB_ADDR_WIDTH = 16;
    localparam int unsigned     MB_RAM_WORDS  = 1024;
    localparam logic [15:0]     MB_IO_BASE    = 16'hFFF0;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        READ,
        WRITE,
        HOLD
    } resp_state_t;

    localparam logic [3:0] IO_SW   = 4'd0;
    localparam logic [3:0] IO_LED  = 4'd1;
    localparam logic [3:0] IO_STAT = 4'd2;

endpackage

// File: rtl/membus_ram.sv
// Single-port synchronous RAM with a registered (1-cycle) read port.
module membus_ram #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned WORDS      = 1024,
    parameter int unsigned AW         = $clog2(WORDS)
) (
    input  logic                  Clock,
    input  logic                  We,
    input  logic [AW-1:0]         Addr,
    input  logic [DATA_WIDTH-1:0] Wd,
    output logic [DATA_WIDTH-1:0] Rd
);

    logic [DATA_WIDTH-1:0] mem_q [WORDS];
    logic [DATA_WIDTH-1:0] rd_q;

    always_ff @(posedge Clock) begin
        if (We) begin
            mem_q[Addr] <= Wd;
        end
        rd_q <= mem_q[Addr];
    end

    assign Rd = rd_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side bus responder: latches address on ALE, decodes to RAM or I/O
// registers, answers read strobes and commits one write per write strobe.
module mem_bus_responder
    import membus_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = MB_DATA_WIDTH,
    parameter int unsigned           ADDR_WIDTH = MB_ADDR_WIDTH,
    parameter int unsigned           RAM_WORDS  = MB_RAM_WORDS,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = MB_IO_BASE
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] DataIn,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  DataOutEn,
    input  logic                  ALE,
    input  logic                  nME,
    input  logic                  nOE,
    input  logic                  nWE,
    input  logic [7:0]            Switches,
    output logic [7:0]            Leds,
    output logic                  BusError
);

    localparam int unsigned           RAM_AW    = $clog2(RAM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] RAM_LIMIT = ADDR_WIDTH'(RAM_WORDS);
    localparam logic [ADDR_WIDTH:0]   IO_END    = (ADDR_WIDTH + 1)'(IO_BASE) + (ADDR_WIDTH + 1)'(16);

    resp_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    data_out_en_q, data_out_en_d;
    logic [7:0]              leds_q, leds_d;
    logic                    bus_error_q, bus_error_d;

    logic                    is_ram_c, is_io_c;
    logic [3:0]              io_off_c;
    logic [DATA_WIDTH-1:0]   rd_val_c;
    logic                    ram_we_c;
    logic [RAM_AW-1:0]       ram_addr_c;
    logic [DATA_WIDTH-1:0]   ram_rd;

    // RAM is addressed from the bus during ALE so its registered read is ready for the strobe edge
    assign ram_addr_c = ALE ? RAM_AW'(DataIn) : RAM_AW'(addr_q);

    membus_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORDS      (RAM_WORDS)
    ) u_ram (
        .Clock (Clock),
        .We    (ram_we_c && !Reset),
        .Addr  (ram_addr_c),
        .Wd    (DataIn),
        .Rd    (ram_rd)
    );

    // Address decode of the latched word address
    always_comb begin
        is_ram_c = (addr_q < RAM_LIMIT);
        is_io_c  = (addr_q >= IO_BASE) && ({1'b0, addr_q} < IO_END);
        io_off_c = 4'(addr_q - IO_BASE);
        rd_val_c = '0;
        if (is_ram_c) begin
            rd_val_c = ram_rd;
        end else if (is_io_c) begin
            case (io_off_c)
                IO_SW:   rd_val_c = DATA_WIDTH'(Switches);
                IO_LED:  rd_val_c = DATA_WIDTH'(leds_q);
                IO_STAT: rd_val_c = DATA_WIDTH'(bus_error_q);
                default: rd_val_c = '0;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        data_out_d    = data_out_q;
        data_out_en_d = data_out_en_q;
        leds_d        = leds_q;
        bus_error_d   = bus_error_q;
        ram_we_c      = 1'b0;

        if (ALE) begin
            addr_d        = ADDR_WIDTH'(DataIn);
            state_d       = ADDR;
            data_out_d    = '0;
            data_out_en_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                ADDR: begin
                    if (!nME && !nOE && nWE) begin
                        data_out_d    = rd_val_c;
                        data_out_en_d = 1'b1;
                        state_d       = READ;
                    end else if (!nME && nOE && !nWE) begin
                        if (is_ram_c) begin
                            ram_we_c = 1'b1;
                        end else if (is_io_c && io_off_c == IO_LED) begin
                            leds_d = DataIn[7:0];
                        end else if (is_io_c && io_off_c == IO_STAT && DataIn[0]) begin
                            bus_error_d = 1'b0;
                        end
                        state_d = WRITE;
                    end else if (!nME && !nOE && !nWE) begin
                        bus_error_d = 1'b1;
                        state_d     = HOLD;
                    end
                end
                READ: begin
                    if (nME || nOE) begin
                        data_out_d    = '0;
                        data_out_en_d = 1'b0;
                        state_d       = IDLE;
                    end
                end
                WRITE, HOLD: begin
                    if (nME) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            data_out_q    <= '0;
            data_out_en_q <= 1'b0;
            leds_q        <= '0;
            bus_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            data_out_q    <= data_out_d;
            data_out_en_q <= data_out_en_d;
            leds_q        <= leds_d;
            bus_error_q   <= bus_error_d;
        end
    end

    assign DataOut   = data_out_q;
    assign DataOutEn = data_out_en_q;
    assign Leds      = leds_q;
    assign BusError  = bus_error_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized self-checking bench for mem_bus_responder against a behavioural memory-map model.
module tb_mem_bus_responder;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] DataIn;
    logic [15:0] DataOut;
    logic        DataOutEn;
    logic        ALE, nME, nOE, nWE;
    logic [7:0]  Switches;
    logic [7:0]  Leds;
    logic        BusError;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the memory map
    logic [15:0] ram_m [1024];
    logic [7:0]  leds_m;
    logic        err_m;
    logic [15:0] written_q [$];

    mem_bus_responder dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .DataIn    (DataIn),
        .DataOut   (DataOut),
        .DataOutEn (DataOutEn),
        .ALE       (ALE),
        .nME       (nME),
        .nOE       (nOE),
        .nWE       (nWE),
        .Switches  (Switches),
        .Leds      (Leds),
        .BusError  (BusError)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] model_read(input logic [15:0] a);
        if (a < 16'd1024)  return ram_m[a[9:0]];
        if (a == 16'hFFF0) return {8'h00, Switches};
        if (a == 16'hFFF1) return {8'h00, leds_m};
        if (a == 16'hFFF2) return {15'd0, err_m};
        return 16'h0000;
    endfunction

    function automatic void model_write(input logic [15:0] a, input logic [15:0] d);
        if (a < 16'd1024) begin
            ram_m[a[9:0]] = d;
            written_q.push_back(a);
        end else if (a == 16'hFFF1) begin
            leds_m = d[7:0];
        end else if (a == 16'hFFF2 && d[0]) begin
            err_m = 1'b0;
        end
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic bus_idle();
        ALE = 1'b0; nME = 1'b1; nOE = 1'b1; nWE = 1'b1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        bus_idle(); ALE = 1'b1; DataIn = a; step();
        ALE = 1'b0; nME = 1'b0; nWE = 1'b0; DataIn = d; step();
        bus_idle(); DataIn = 16'($urandom); step();
        model_write(a, d);
    endtask

    // Fetch-shaped read: en = {after ALE, strobe cycle, ENB cycle, after release}
    task automatic bus_read(input logic [15:0] a, output logic [15:0] d1, output logic [15:0] d2,
                            output logic [3:0] en, output logic [15:0] d_rel);
        bus_idle(); ALE = 1'b1; DataIn = a; step();
        en[3] = DataOutEn;
        ALE = 1'b0; nME = 1'b0; nOE = 1'b0; DataIn = 16'($urandom); step();
        d1 = DataOut; en[2] = DataOutEn;
        DataIn = 16'($urandom); step();
        d2 = DataOut; en[1] = DataOutEn;
        bus_idle(); step();
        en[0] = DataOutEn; d_rel = DataOut;
    endtask

    task automatic test_reset();
        logic [15:0] d1, d2, dr;
        logic [3:0]  en;
        bus_idle(); DataIn = '0; Switches = 8'h00; Reset = 1'b1;
        step(); step();
        Reset = 1'b0;
        n_checks++; if ({DataOutEn, DataOut, Leds, BusError} !== 26'd0) begin
            n_fail++; $display("FAIL reset_initial: got en=%b do=%h leds=%h err=%b want all 0", DataOutEn, DataOut, Leds, BusError);
        end
        leds_m = 8'h00; err_m = 1'b0;
        bus_write(16'h0040, 16'h7777);
        bus_write(16'hFFF1, 16'h00FF);
        // Reset for two cycles in the middle of a read
        bus_idle(); ALE = 1'b1; DataIn = 16'h0040; step();
        ALE = 1'b0; nME = 1'b0; nOE = 1'b0; step();
        n_checks++; if (DataOut !== 16'h7777 || DataOutEn !== 1'b1) begin
            n_fail++; $display("FAIL reset_preread: got do=%h en=%b want 7777 1", DataOut, DataOutEn);
        end
        Reset = 1'b1; step(); step();
        n_checks++; if ({DataOutEn, DataOut, Leds, BusError} !== 26'd0) begin
            n_fail++; $display("FAIL reset_midread: got en=%b do=%h leds=%h err=%b want all 0", DataOutEn, DataOut, Leds, BusError);
        end
        leds_m = 8'h00; err_m = 1'b0;
        Reset = 1'b0; step();
        n_checks++; if (DataOutEn !== 1'b0 || DataOut !== 16'h0000) begin
            n_fail++; $display("FAIL reset_idle_ignores_strobe: got en=%b do=%h want 0 0000", DataOutEn, DataOut);
        end
        bus_idle(); step();
        bus_read(16'h0040, d1, d2, en, dr);
        n_checks++; if (d1 !== 16'h7777) begin
            n_fail++; $display("FAIL reset_ram_kept: got %h want 7777", d1);
        end
    endtask

    task automatic test_write_read();
        logic [15:0] d1, d2, dr;
        logic [3:0]  en;
        bus_write(16'h0010, 16'hBEEF);
        bus_read(16'h0010, d1, d2, en, dr);
        n_checks++; if (d1 !== 16'hBEEF || en[2] !== 1'b1) begin
            n_fail++; $display("FAIL write_read: got do=%h en=%b want beef 1", d1, en[2]);
        end
    endtask

    task automatic test_fetch();
        logic [15:0] d1, d2, dr;
        logic [3:0]  en;
        bus_write(16'h03FF, 16'h1234);
        bus_read(16'h03FF, d1, d2, en, dr);
        n_checks++; if (d1 !== 16'h1234 || d2 !== 16'h1234) begin
            n_fail++; $display("FAIL fetch_data: got %h %h want 1234 1234", d1, d2);
        end
        n_checks++; if (en !== 4'b0110 || dr !== 16'h0000) begin
            n_fail++; $display("FAIL fetch_enable: got en=%b rel=%h want 0110 0000", en, dr);
        end
    endtask

    task automatic test_io();
        logic [15:0] d1, d2, dr;
        logic [3:0]  en;
        bus_write(16'hFFF1, 16'h00A5);
        n_checks++; if (Leds !== 8'hA5) begin
            n_fail++; $display("FAIL io_leds: got %h want a5", Leds);
        end
        Switches = 8'h3C;
        bus_read(16'hFFF0, d1, d2, en, dr);
        n_checks++; if (d1 !== 16'h003C) begin
            n_fail++; $display("FAIL io_switches: got %h want 003c", d1);
        end
        bus_read(16'hFFF1, d1, d2, en, dr);
        n_checks++; if (d1 !== 16'h00A5) begin
            n_fail++; $display("FAIL io_leds_read: got %h want 00a5", d1);
        end
        bus_write(16'h0800, 16'hDEAD);
        bus_read(16'h0800, d1, d2, en, dr);
        n_checks++; if (d1 !== 16'h0000 || en !== 4'b0110) begin
            n_fail++; $display("FAIL io_unmapped: got %h en=%b want 0000 0110", d1, en);
        end
        bus_write(16'hFFF0, 16'hFFFF);
        bus_read(16'hFFF0, d1, d2, en, dr);
        n_checks++; if (d1 !== 16'h003C) begin
            n_fail++; $display("FAIL io_switches_ro: got %h want 003c", d1);
        end
    endtask

    task automatic test_bus_error();
        logic [15:0] d1, d2, dr;
        logic [3:0]  en;
        bus_write(16'h0020, 16'h5555);
        bus_idle(); ALE = 1'b1; DataIn = 16'h0020; step();
        ALE = 1'b0; nME = 1'b0; nOE = 1'b0; nWE = 1'b0; DataIn = 16'hAAAA; step();
        err_m = 1'b1;
        n_checks++; if (BusError !== 1'b1 || DataOutEn !== 1'b0) begin
            n_fail++; $display("FAIL err_set: got err=%b en=%b want 1 0", BusError, DataOutEn);
        end
        step();
        bus_idle(); step();
        bus_read(16'h0020, d1, d2, en, dr);
        n_checks++; if (d1 !== 16'h5555) begin
            n_fail++; $display("FAIL err_no_write: got %h want 5555", d1);
        end
        bus_read(16'hFFF2, d1, d2, en, dr);
        n_checks++; if (d1 !== 16'h0001) begin
            n_fail++; $display("FAIL err_status: got %h want 0001", d1);
        end
        bus_write(16'hFFF2, 16'h0000);
        n_checks++; if (BusError !== 1'b1) begin
            n_fail++; $display("FAIL err_write0_keeps: got %b want 1", BusError);
        end
        bus_write(16'hFFF2, 16'h0001);
        n_checks++; if (BusError !== 1'b0) begin
            n_fail++; $display("FAIL err_clear: got %b want 0", BusError);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d1, d2, dr;
        logic [3:0]  en;
        // Write strobe held for several cycles with changing data
        bus_idle(); ALE = 1'b1; DataIn = 16'h0030; step();
        ALE = 1'b0; nME = 1'b0; nWE = 1'b0; DataIn = 16'h1111; step();
        DataIn = 16'h2222; step();
        DataIn = 16'h3333; step();
        nWE = 1'b1; DataIn = 16'h4444; step();
        nWE = 1'b0; DataIn = 16'h5555; step();
        bus_idle(); step();
        model_write(16'h0030, 16'h1111);
        bus_read(16'h0030, d1, d2, en, dr);
        n_checks++; if (d1 !== 16'h1111) begin
            n_fail++; $display("FAIL write_once: got %h want 1111", d1);
        end
        // ALE arriving during a read
        bus_idle(); ALE = 1'b1; DataIn = 16'h0010; step();
        ALE = 1'b0; nME = 1'b0; nOE = 1'b0; step();
        ALE = 1'b1; DataIn = 16'h03FF; step();
        n_checks++; if (DataOutEn !== 1'b0 || DataOut !== 16'h0000) begin
            n_fail++; $display("FAIL ale_in_read: got en=%b do=%h want 0 0000", DataOutEn, DataOut);
        end
        ALE = 1'b0; step();
        n_checks++; if (DataOut !== model_read(16'h03FF) || DataOutEn !== 1'b1) begin
            n_fail++; $display("FAIL ale_new_addr: got %h en=%b want %h 1", DataOut, DataOutEn, model_read(16'h03FF));
        end
        bus_idle(); step();
    endtask

    task automatic test_random();
        logic [15:0] a, d, d1, d2, dr;
        logic [3:0]  en;
        int          op;
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 6));
            a  = 16'h0000;
            d  = 16'($urandom);
            case (op)
                0: begin a = 16'($urandom_range(0, 1023)); bus_write(a, d); end
                1: a = written_q[$urandom_range(0, written_q.size() - 1)];
                2: begin a = 16'hFFF1; bus_write(a, d); end
                3: begin Switches = 8'($urandom); a = 16'hFFF0; end
                4: a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(1024, 16'hFFEF))
                                                   : 16'($urandom_range(16'hFFF3, 16'hFFFF));
                5: begin a = 16'hFFF2; bus_write(a, d); end
                default: begin
                    a = written_q[$urandom_range(0, written_q.size() - 1)];
                    bus_idle(); ALE = 1'b1; DataIn = a; step();
                    ALE = 1'b0; nME = 1'b0; nOE = 1'b0; nWE = 1'b0; DataIn = d; step();
                    bus_idle(); step();
                    err_m = 1'b1;
                end
            endcase
            bus_read(a, d1, d2, en, dr);
            n_checks++; if (d1 !== model_read(a) || d2 !== model_read(a)) begin
                n_fail++; $display("FAIL rand_read[%0d] op%0d @%h: got %h %h want %h", i, op, a, d1, d2, model_read(a));
            end
            n_checks++; if (en !== 4'b0110 || dr !== 16'h0000) begin
                n_fail++; $display("FAIL rand_enable[%0d]: got en=%b rel=%h want 0110 0000", i, en, dr);
            end
            n_checks++; if (Leds !== leds_m || BusError !== err_m) begin
                n_fail++; $display("FAIL rand_regs[%0d]: got leds=%h err=%b want %h %b", i, Leds, BusError, leds_m, err_m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_fetch();
        test_io();
        test_bus_error();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
